ahb3lite_master_if: RTL and testbench
=====================================

# ahb3lite_master_if

AHB-Lite single-transfer bus master that converts a simple valid/ready command stream into pipelined NONSEQ/SINGLE AHB-Lite transfers. It drives the manager side of the bus that the SRAM slave wrapper terminates, and returns one response per command. Address and data phases overlap, so back-to-back commands sustain one transfer per cycle with zero-wait slaves. Wait states and the two-cycle ERROR response are handled; a transfer cancelled by an error is replayed automatically.

## Interface
- ADDR_W, 32, HADDR and cmd_addr width
- DATA_W, 32, HWDATA/HRDATA width (32 only, verified)
- HPROT_VAL, 4'b0011, constant HPROT value (non-cacheable, privileged, data)

- HCLK  in  1  bus clock; all state on rising edge
- HRESETn  in  1  asynchronous active-low reset (one clock; reset asynchronous, active-low)
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted at the rising edge where cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address, passed to HADDR unmodified
- cmd_size  in  3  HSIZE code (0 byte, 1 half, 2 word)
- cmd_wdata  in  DATA_W  write data, already lane-aligned
- rsp_valid  out  1  one-cycle pulse, one per command, in command order
- rsp_rdata  out  DATA_W  HRDATA captured for reads; 0 for writes
- rsp_err  out  1  slave returned ERROR
- busy  out  1  address or data phase occupied
- HADDR  out  ADDR_W;  HWRITE  out  1;  HSIZE  out  3;  HBURST  out  3 (always 3'b000);  HPROT  out  4 (HPROT_VAL);  HMASTLOCK  out  1 (always 0);  HTRANS  out  2 (IDLE 2'b00 / NONSEQ 2'b10)
- HWDATA  out  DATA_W  write data in data phase
- HRDATA  in  DATA_W;  HREADY  in  1;  HRESP  in  1

## Operation
- Two stages: AP (address-phase regs: valid, hold, addr, write, size, wdata) and DP (data-phase regs: valid, write, wdata).
- cmd_ready = HREADY && !(DP.valid && HRESP) && !AP.hold. Combinational, no dependence on cmd_valid.
- Edge with HREADY=1 and no error first cycle: AP loads the accepted command (HTRANS=NONSEQ) or becomes IDLE; the old AP content moves to DP; HWDATA updated from the moved AP wdata on writes.
- HREADY=0 and HRESP=0: all bus outputs and regs hold (wait state).
- Error first cycle (DP.valid, HRESP=1, HREADY=0): at that edge HTRANS forced IDLE, AP.hold=1, AP addr/write/size/wdata kept; DP holds.
- Error second cycle (HRESP=1, HREADY=1): DP completes with rsp_err=1; the IDLE AP completes; no new command accepted; next cycle AP re-issues NONSEQ from held regs, hold cleared.
- DP completion (DP.valid && HREADY=1): next cycle rsp_valid=1, rsp_err=HRESP, rsp_rdata=HRDATA for reads, 0 for writes.
- Responses have no backpressure; consumer must sample every pulse.
- busy = AP.valid || AP.hold || DP.valid.

## Timing
- Reset (async assert, sync-safe release): HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, AP/DP invalid. HBURST/HPROT/HMASTLOCK constant.
- Reset mid-transfer: in-flight AP/DP dropped, no response produced.
- Latency zero-wait: accept at edge E0; NONSEQ on bus E0..E1; data phase E1..E2; rsp_valid high E2..E3 (3 edges). Each slave wait state adds one cycle.
- Throughput: one command per cycle with zero-wait slave and continuous cmd_valid.
- Error on transfer N with N+1 in AP: responses N (err=1) then N+1 (from replay); N+1 is issued to the bus twice, once cancelled as IDLE.
- HRESP=1 with HREADY=1 and no error first cycle seen: treated as error completion, rsp_err=1, no replay.

## Test plan
- Write 0xDEADBEEF size 2 to 0x10, then read 0x10 through SRAM slave -> two responses, second rsp_rdata=0xDEADBEEF, rsp_err=0, read rsp_valid at E2 after its accept.
- 8 back-to-back writes then 8 reads, zero-wait -> HTRANS NONSEQ 8 consecutive cycles, cmd_ready constantly 1, 16 in-order responses with correct data.
- Slave inserts 3 wait states on second of three reads -> bus outputs frozen 3 cycles, cmd_ready=0 during waits, responses delayed by exactly 3 cycles.
- ERROR on write to 0x40 with read 0x44 pipelined -> HTRANS IDLE in second error cycle, rsp_err=1 for 0x40, 0x44 re-issued NONSEQ next cycle, its response rsp_err=0.
- Assert HRESETn low while DP busy -> all outputs at reset values immediately, no rsp_valid after release, next command completes normally.

Source files
------------

// File: rtl/ahb3lite_master_if.sv
// AHB-Lite single-transfer master: valid/ready commands become pipelined NONSEQ/SINGLE transfers.
// Response 3 edges after accept with zero-wait slave; cmd_ready drops on wait, error or replay hold.
module ahb3lite_master_if #(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [1:0]        HTRANS,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic              ap_valid;
    logic              ap_hold;
    logic              ap_write;
    logic [ADDR_W-1:0] ap_addr;
    logic [2:0]        ap_size;
    logic [DATA_W-1:0] ap_wdata;

    logic              dp_valid;
    logic              dp_write;
    logic [DATA_W-1:0] dp_wdata;

    logic dp_err;
    logic err_first;
    logic accept;

    assign dp_err    = dp_valid && HRESP;
    assign err_first = dp_err && !HREADY;
    assign cmd_ready = HREADY && !dp_err && !ap_hold;
    assign accept    = cmd_valid && cmd_ready;

    assign HADDR     = ap_addr;
    assign HWRITE    = ap_write;
    assign HSIZE     = ap_size;
    assign HTRANS    = ap_valid ? TRANS_NONSEQ : TRANS_IDLE;
    assign HWDATA    = dp_wdata;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign busy      = ap_valid || ap_hold || dp_valid;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid  <= 1'b0;
            ap_hold   <= 1'b0;
            ap_write  <= 1'b0;
            ap_addr   <= '0;
            ap_size   <= 3'b000;
            ap_wdata  <= '0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            if (HREADY) begin
                rsp_valid <= dp_valid;
                rsp_err   <= dp_err;
                rsp_rdata <= (dp_valid && !dp_write) ? HRDATA : '0;
                dp_valid  <= ap_valid;
                dp_write  <= ap_write;
                if (ap_valid && ap_write) begin
                    dp_wdata <= ap_wdata;
                end
                if (ap_hold) begin
                    // Second error cycle just retired the cancelled slot; replay from held regs.
                    ap_valid <= 1'b1;
                    ap_hold  <= 1'b0;
                end else if (accept) begin
                    ap_valid <= 1'b1;
                    ap_write <= cmd_write;
                    ap_addr  <= cmd_addr;
                    ap_size  <= cmd_size;
                    ap_wdata <= cmd_wdata;
                end else begin
                    ap_valid <= 1'b0;
                end
            end else if (err_first && !ap_hold) begin
                // Cancel the pipelined transfer; only hold it if there was one to replay.
                ap_valid <= 1'b0;
                ap_hold  <= ap_valid;
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_master_if.sv
// Bench for ahb3lite_master_if: SRAM-like AHB slave with waits/errors, in-order response scoreboard.
module tb_ahb3lite_master_if;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          waits;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          acc_cyc;
    } cmd_t;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahb3lite_master_if dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_rsp       = 0;
    logic bubbles   = 1'b0;

    cmd_t pend[$];
    cmd_t expq[$];
    cmd_t busq[$];
    cmd_t tbl[$];

    logic [31:0] mem     [0:31];
    logic [31:0] ref_mem [0:31];

    // slave data-phase state
    logic        s_active = 1'b0;
    logic [31:0] s_addr   = '0;
    logic        s_write  = 1'b0;
    logic [31:0] s_wdata  = '0;
    logic        s_err    = 1'b0;
    logic        s_errph  = 1'b0;
    int          s_waits  = 0;
    logic        prev_wait = 1'b0;
    logic [69:0] prev_bus  = '0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return a[31:2] == 30'h10;
    endfunction

    // In-order command semantics: erroring accesses fail and leave memory untouched.
    function automatic cmd_t predict(input cmd_t c);
        cmd_t r = c;
        r.exp_err   = 1'b0;
        r.exp_rdata = '0;
        if (is_err(c.addr)) begin
            r.exp_err = 1'b1;
        end else if (c.write) begin
            ref_mem[c.addr[6:2]] = c.wdata;
        end else begin
            r.exp_rdata = ref_mem[c.addr[6:2]];
        end
        return r;
    endfunction

    function automatic cmd_t mk(input logic w, input logic [31:0] a, input logic [2:0] s,
                                input logic [31:0] d, input int wt, input logic ee,
                                input logic [31:0] er, input int lat);
        cmd_t c;
        c.write = w; c.addr = a; c.size = s; c.wdata = d; c.waits = wt;
        c.exp_err = ee; c.exp_rdata = er; c.exp_lat = lat; c.acc_cyc = 0;
        return c;
    endfunction

    task automatic cycle();
        cmd_t c;
        cmd_t e;
        @(posedge HCLK);
        #1;
        cyc++;
        HRDATA = $urandom;
        if (!s_active) begin
            HREADY = 1'b1; HRESP = 1'b0;
        end else if (s_waits > 0) begin
            HREADY = 1'b0; HRESP = 1'b0;
        end else if (s_err && !s_errph) begin
            HREADY = 1'b0; HRESP = 1'b1; HRDATA = '0;
        end else if (s_err) begin
            HREADY = 1'b1; HRESP = 1'b1; HRDATA = '0;
        end else begin
            HREADY = 1'b1; HRESP = 1'b0;
            if (!s_write) HRDATA = mem[s_addr[6:2]];
        end
        if (pend.size() > 0 && (!bubbles || $urandom_range(0, 3) != 0)) begin
            cmd_valid = 1'b1;
            cmd_write = pend[0].write;
            cmd_addr  = pend[0].addr;
            cmd_size  = pend[0].size;
            cmd_wdata = pend[0].wdata;
        end else begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_size  = 3'($urandom_range(0, 7));
            cmd_wdata = $urandom;
        end

        @(negedge HCLK);
        if (expq.size() == 0) begin
            check("rsp_unexpected", 72'(rsp_valid), 72'(0));
        end else if (rsp_valid) begin
            e = expq.pop_front();
            check("rsp_err", 72'(rsp_err), 72'(e.exp_err));
            check("rsp_rdata", 72'(rsp_rdata), 72'(e.exp_rdata));
            if (e.exp_lat != 0) check("rsp_latency", 72'(cyc - e.acc_cyc), 72'(e.exp_lat));
        end
        if (rsp_valid) n_rsp++;
        check("busy", 72'(busy), 72'(expq.size() > 0));
        check("cmd_ready", 72'(cmd_ready), 72'(HREADY && !HRESP));
        if (HREADY && HRESP) check("err2_htrans_idle", 72'(HTRANS), 72'(0));
        if (prev_wait) check("wait_freeze", 72'({HTRANS, HADDR, HWRITE, HSIZE, HWDATA}), 72'(prev_bus));

        if (s_active) begin
            if (s_waits > 0) begin
                s_waits--;
            end else if (s_err && !s_errph) begin
                s_errph = 1'b1;
            end else begin
                if (s_write && !s_err) begin
                    check("hwdata", 72'(HWDATA), 72'(s_wdata));
                    mem[s_addr[6:2]] = HWDATA;
                end
                s_active = 1'b0;
            end
        end
        if (HREADY && HTRANS == 2'b10) begin
            if (busq.size() == 0) begin
                check("bus_extra_nonseq", 72'(HTRANS), 72'(0));
            end else begin
                c = busq.pop_front();
                check("haddr", 72'(HADDR), 72'(c.addr));
                check("hwrite", 72'(HWRITE), 72'(c.write));
                check("hsize", 72'(HSIZE), 72'(c.size));
                s_active = 1'b1;
                s_addr   = HADDR;
                s_write  = HWRITE;
                s_wdata  = c.wdata;
                s_err    = is_err(HADDR);
                s_errph  = 1'b0;
                s_waits  = c.waits;
            end
        end

        if (cmd_valid && cmd_ready) begin
            c = pend.pop_front();
            c.acc_cyc = cyc;
            expq.push_back(c);
            busq.push_back(c);
        end
        prev_wait = !HREADY && !HRESP;
        prev_bus  = {HTRANS, HADDR, HWRITE, HSIZE, HWDATA};
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((pend.size() > 0 || expq.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 72'(pend.size() + expq.size()), 72'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_htrans"}, 72'(HTRANS), 72'(0));
        check({tag, "_haddr"}, 72'(HADDR), 72'(0));
        check({tag, "_hwrite"}, 72'(HWRITE), 72'(0));
        check({tag, "_hsize"}, 72'(HSIZE), 72'(0));
        check({tag, "_hwdata"}, 72'(HWDATA), 72'(0));
        check({tag, "_rsp_valid"}, 72'(rsp_valid), 72'(0));
        check({tag, "_rsp_rdata"}, 72'(rsp_rdata), 72'(0));
        check({tag, "_rsp_err"}, 72'(rsp_err), 72'(0));
        check({tag, "_busy"}, 72'(busy), 72'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c;
        int   rsp_before;
        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_size = 3'd0; cmd_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem[i[4:0]]     = 32'hC0DE_0000 + 32'(i);
            ref_mem[i[4:0]] = 32'hC0DE_0000 + 32'(i);
        end
        repeat (3) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(negedge HCLK);
        check_reset_outputs("reset");
        check("reset_cmd_ready", 72'(cmd_ready), 72'(1));
        check("hburst", 72'(HBURST), 72'(0));
        check("hprot", 72'(HPROT), 72'(4'b0011));
        check("hmastlock", 72'(HMASTLOCK), 72'(0));

        // Directed vectors: latency, back-to-back throughput, wait states, error replay.
        tbl.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 1'b0, 32'h0, 3));
        tbl.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 0, 1'b0, 32'hDEADBEEF, 3));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b1, 32'(4 * i), 3'd2, 32'hA000_0000 + 32'(i), 0, 1'b0, 32'h0, 3));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1'b0, 32'(4 * i), 3'd2, 32'h0, 0, 1'b0, 32'hA000_0000 + 32'(i), 3));
        tbl.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0, 0, 1'b0, 32'hA000_0000, 3));
        tbl.push_back(mk(1'b0, 32'h04, 3'd2, 32'h0, 3, 1'b0, 32'hA000_0001, 6));
        tbl.push_back(mk(1'b0, 32'h08, 3'd2, 32'h0, 0, 1'b0, 32'hA000_0002, 6));
        tbl.push_back(mk(1'b1, 32'h40, 3'd2, 32'h12345678, 0, 1'b1, 32'h0, 4));
        tbl.push_back(mk(1'b0, 32'h44, 3'd2, 32'h0, 0, 1'b0, 32'hC0DE_0011, 5));
        tbl.push_back(mk(1'b1, 32'h44, 3'd2, 32'h55AA55AA, 0, 1'b0, 32'h0, 0));
        tbl.push_back(mk(1'b0, 32'h44, 3'd2, 32'h0, 0, 1'b0, 32'h55AA55AA, 0));
        tbl.push_back(mk(1'b0, 32'h13, 3'd0, 32'h0, 0, 1'b0, 32'hA000_0004, 0));
        tbl.push_back(mk(1'b0, 32'h40, 3'd2, 32'h0, 0, 1'b1, 32'h0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            c = predict(tbl[i]);
            c.exp_err   = tbl[i].exp_err;
            c.exp_rdata = tbl[i].exp_rdata;
            pend.push_back(c);
        end
        run_until_idle(200);

        // Randomized traffic against the reference model.
        bubbles = 1'b1;
        for (int i = 0; i < 400; i++) begin
            c.write   = 1'($urandom_range(0, 1));
            c.addr    = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
            c.size    = c.write ? 3'd2 : 3'($urandom_range(0, 2));
            c.wdata   = $urandom;
            c.waits   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            c.exp_lat = 0;
            c.acc_cyc = 0;
            pend.push_back(predict(c));
        end
        run_until_idle(8000);
        bubbles = 1'b0;

        // Reset while a read sits in a long data phase.
        pend.push_back(predict(mk(1'b0, 32'h20, 3'd2, 32'h0, 6, 1'b0, 32'h0, 0)));
        repeat (3) cycle();
        check("pre_reset_busy", 72'(busy), 72'(1));
        #2 HRESETn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        pend.delete(); expq.delete(); busq.delete();
        s_active = 1'b0; prev_wait = 1'b0;
        cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK);
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        rsp_before = n_rsp;
        repeat (6) cycle();
        check("rsp_after_reset", 72'(n_rsp - rsp_before), 72'(0));
        pend.push_back(predict(mk(1'b1, 32'h24, 3'd2, 32'h0BADF00D, 0, 1'b0, 32'h0, 3)));
        pend.push_back(predict(mk(1'b0, 32'h24, 3'd2, 32'h0, 0, 1'b0, 32'h0, 3)));
        check("post_reset_model", 72'(pend[1].exp_rdata), 72'(32'h0BADF00D));
        run_until_idle(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
